ad_top: RTL and testbench

- SPI master for a 12-bit serial ADC with 4-bit channel addressing.
- Scans the channel chosen by Switch, converts each result to 3-digit BCD and presents the result with the channel it came from.
- Sits between the board ADC pins and the display/LED logic; BCD output feeds the 7-segment driver.

---
 rtl/ad_top.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ad_top.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_top.sv
// ad_top: SPI master for a 12-bit serial ADC; scans the Switch-selected channel and outputs 3-digit BCD.
// Build option AD_AVG_EN: average 4 consecutive same-channel samples before each output update.
module ad_top #(
  parameter int unsigned CLK_DIV = 25,
  parameter int unsigned T_QUIET = 100
) (
  input  logic        CLK,
  input  logic        Sys_RST,
  input  logic [1:0]  Switch,
  input  logic        SDI,
  output logic        SCLK,
  output logic        CS,
  output logic        SDO,
  output logic [11:0] AD_BCDOut,
  output logic [3:0]  AD_Address
);

  localparam int unsigned DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned QW        = (T_QUIET > 1) ? $clog2(T_QUIET) : 1;
  localparam int unsigned HW        = 6;
  localparam int unsigned FW        = 16;
  localparam int unsigned RW        = 12;
  localparam int unsigned VW        = 10;
  localparam int unsigned BW        = 12;
  localparam int unsigned IW        = 4;
  localparam int unsigned AW        = 4;
  localparam int unsigned HALVES    = 33;
  localparam int unsigned RX_HALVES = 2 * RW;
  localparam int unsigned DD_ITERS  = 10;
  localparam int unsigned SAT_VAL   = 999;
`ifdef AD_AVG_EN
  localparam int unsigned SW        = 14;
`endif

  typedef enum logic [1:0] {
    ST_QUIET   = 2'd0,
    ST_FRAME   = 2'd1,
    ST_CONVERT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   quiet_cnt_q, quiet_cnt_d;
  logic [DW-1:0]   div_cnt_q, div_cnt_d;
  logic [HW-1:0]   half_cnt_q, half_cnt_d;
  logic            sclk_q, sclk_d;
  logic            cs_q, cs_d;
  logic [FW-1:0]   tx_q, tx_d;
  logic [RW-1:0]   rx_q, rx_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   prev_addr_q, prev_addr_d;
  logic            prev_valid_q, prev_valid_d;
  logic [AW-1:0]   conv_addr_q, conv_addr_d;
  logic [VW-1:0]   bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [IW-1:0]   iter_q, iter_d;
  logic [BW-1:0]   bcd_out_q, bcd_out_d;
  logic [AW-1:0]   addr_out_q, addr_out_d;
`ifdef AD_AVG_EN
  logic [SW-1:0]   acc_q, acc_d;
  logic [1:0]      acc_cnt_q, acc_cnt_d;
  logic [AW-1:0]   acc_addr_q, acc_addr_d;
  logic [SW-1:0]   acc_sum;
  logic            unused_sum_lsb;
`else
  logic            unused_rx_lsb;
`endif

  logic [VW-1:0]   val_raw;
  logic [VW-1:0]   val_sat;
  logic [BW-1:0]   dd_adj;
  logic [BW-1:0]   dd_bcd;
  logic [VW-1:0]   dd_bin;

  // Value to convert: top 10 bits of the sample (or of the 4-sample sum), clamped to 999
`ifdef AD_AVG_EN
  assign acc_sum        = acc_q + SW'(rx_q);
  assign val_raw        = acc_sum[SW-1:4];
  assign unused_sum_lsb = ^acc_sum[3:0];
`else
  assign val_raw        = rx_q[RW-1:2];
  assign unused_rx_lsb  = ^rx_q[1:0];
`endif
  assign val_sat = (val_raw > VW'(SAT_VAL)) ? VW'(SAT_VAL) : val_raw;

  // One double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit
  always_comb begin
    dd_adj = bcd_q;
    for (int d = 0; d < 3; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) begin
        dd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
    end
    dd_bcd = {dd_adj[BW-2:0], bin_q[VW-1]};
    dd_bin = {bin_q[VW-2:0], 1'b0};
  end

  always_comb begin
    state_d      = state_q;
    quiet_cnt_d  = quiet_cnt_q;
    div_cnt_d    = div_cnt_q;
    half_cnt_d   = half_cnt_q;
    sclk_d       = sclk_q;
    cs_d         = cs_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    addr_d       = addr_q;
    prev_addr_d  = prev_addr_q;
    prev_valid_d = prev_valid_q;
    conv_addr_d  = conv_addr_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    iter_d       = iter_q;
    bcd_out_d    = bcd_out_q;
    addr_out_d   = addr_out_q;
`ifdef AD_AVG_EN
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    acc_addr_d   = acc_addr_q;
`endif

    unique case (state_q)
      ST_QUIET: begin
        if (quiet_cnt_q == QW'(T_QUIET - 1)) begin
          state_d     = ST_FRAME;
          quiet_cnt_d = '0;
          cs_d        = 1'b0;
          sclk_d      = 1'b0;
          div_cnt_d   = '0;
          half_cnt_d  = '0;
          addr_d      = {2'b00, Switch};
          tx_d        = {2'b00, Switch, 12'h000};
        end else begin
          quiet_cnt_d = quiet_cnt_q + QW'(1);
        end
      end

      ST_FRAME: begin
        if (div_cnt_q == DW'(CLK_DIV - 1)) begin
          div_cnt_d  = '0;
          half_cnt_d = half_cnt_q + HW'(1);
          if (half_cnt_q == HW'(HALVES - 1)) begin
            // Frame done: this frame's data belongs to the address sent in the previous frame
            cs_d         = 1'b1;
            half_cnt_d   = '0;
            quiet_cnt_d  = '0;
            prev_addr_d  = addr_q;
            prev_valid_d = 1'b1;
            conv_addr_d  = prev_addr_q;
            bin_d        = val_sat;
            bcd_d        = '0;
            iter_d       = '0;
            state_d      = ST_QUIET;
            if (prev_valid_q) begin
`ifdef AD_AVG_EN
              if (acc_cnt_q == 2'd0 || acc_addr_q != prev_addr_q) begin
                acc_d      = SW'(rx_q);
                acc_cnt_d  = 2'd1;
                acc_addr_d = prev_addr_q;
              end else if (acc_cnt_q == 2'd3) begin
                acc_d      = '0;
                acc_cnt_d  = 2'd0;
                state_d    = ST_CONVERT;
              end else begin
                acc_d      = acc_sum;
                acc_cnt_d  = acc_cnt_q + 2'd1;
              end
`else
              state_d = ST_CONVERT;
`endif
            end
          end else begin
            sclk_d = ~sclk_q;
            if (!sclk_q) begin
              if (half_cnt_q < HW'(RX_HALVES)) begin
                rx_d = {rx_q[RW-2:0], SDI};
              end
            end else begin
              tx_d = {tx_q[FW-2:0], 1'b0};
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end

      ST_CONVERT: begin
        bcd_d  = dd_bcd;
        bin_d  = dd_bin;
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(DD_ITERS - 1)) begin
          bcd_out_d   = dd_bcd;
          addr_out_d  = conv_addr_q;
          quiet_cnt_d = '0;
          state_d     = ST_QUIET;
        end
      end

      default: begin
        state_d     = ST_QUIET;
        quiet_cnt_d = '0;
        cs_d        = 1'b1;
        sclk_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Sys_RST) begin
      state_q      <= ST_QUIET;
      quiet_cnt_q  <= '0;
      div_cnt_q    <= '0;
      half_cnt_q   <= '0;
      sclk_q       <= 1'b0;
      cs_q         <= 1'b1;
      tx_q         <= '0;
      rx_q         <= '0;
      addr_q       <= '0;
      prev_addr_q  <= '0;
      prev_valid_q <= 1'b0;
      conv_addr_q  <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      bcd_out_q    <= '0;
      addr_out_q   <= '0;
`ifdef AD_AVG_EN
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      acc_addr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      quiet_cnt_q  <= quiet_cnt_d;
      div_cnt_q    <= div_cnt_d;
      half_cnt_q   <= half_cnt_d;
      sclk_q       <= sclk_d;
      cs_q         <= cs_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      addr_q       <= addr_d;
      prev_addr_q  <= prev_addr_d;
      prev_valid_q <= prev_valid_d;
      conv_addr_q  <= conv_addr_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      iter_q       <= iter_d;
      bcd_out_q    <= bcd_out_d;
      addr_out_q   <= addr_out_d;
`ifdef AD_AVG_EN
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_addr_q   <= acc_addr_d;
`endif
    end
  end

  assign SCLK       = sclk_q;
  assign CS         = cs_q;
  assign SDO        = tx_q[FW-1];
  assign AD_BCDOut  = bcd_out_q;
  assign AD_Address = addr_out_q;

endmodule

// File: tb/tb_ad_top.sv
// tb_ad_top: self-checking bench for ad_top with a serial ADC model and a frame-level reference model.
module tb_ad_top;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned T_QUIET = 20;
  localparam int          TMO     = 2000;

  logic        CLK = 1'b0;
  logic        Sys_RST = 1'b1;
  logic [1:0]  Switch = 2'd2;
  logic        SDI = 1'b0;
  logic        SCLK, CS, SDO;
  logic [11:0] AD_BCDOut;
  logic [3:0]  AD_Address;

  ad_top #(.CLK_DIV(CLK_DIV), .T_QUIET(T_QUIET)) dut (
    .CLK(CLK), .Sys_RST(Sys_RST), .Switch(Switch), .SDI(SDI),
    .SCLK(SCLK), .CS(CS), .SDO(SDO), .AD_BCDOut(AD_BCDOut), .AD_Address(AD_Address)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // ADC model state: returns the stored value of the channel addressed in the previous complete frame
  logic [11:0] adc_mem [4];
  logic [3:0]  adc_last = 4'd0;
  logic [15:0] dout_sh = '0;
  logic [15:0] din_sh = '0;
  logic [11:0] cur_data = '0;
  int          pulses = 0;
  logic        cs_p = 1'b1;
  logic        sclk_p = 1'b0;
  logic [3:0]  rec_addr = '0;
  logic [11:0] rec_data = '0;
  int          rec_pulses = 0;
  logic [15:0] out_p = '0;
  int          upd_cnt = 0;

  // Reference model state
  logic [15:0] exp_out = '0;
  bit          have_prev = 1'b0;
  logic [3:0]  prev_sent = '0;
`ifdef AD_AVG_EN
  int          avg_sum = 0;
  int          avg_n = 0;
  logic [3:0]  avg_ch = '0;
`endif

  always @(negedge CLK) begin
    if (CS === 1'b0 && cs_p === 1'b1) begin
      cur_data = adc_mem[adc_last[1:0]];
      dout_sh  = {cur_data, 4'($urandom)};
      SDI      = dout_sh[15];
      pulses   = 0;
      din_sh   = '0;
    end else if (CS === 1'b0) begin
      if (SCLK === 1'b1 && sclk_p === 1'b0) begin
        pulses++;
        din_sh = {din_sh[14:0], SDO};
      end
      if (SCLK === 1'b0 && sclk_p === 1'b1) begin
        dout_sh = {dout_sh[14:0], 1'b0};
        SDI     = dout_sh[15];
      end
    end
    if (CS === 1'b1 && cs_p === 1'b0) begin
      rec_addr   = din_sh[15:12];
      rec_data   = cur_data;
      rec_pulses = pulses;
      if (pulses == 16) adc_last = din_sh[15:12];
    end
    cs_p   = CS;
    sclk_p = SCLK;
    if ({AD_Address, AD_BCDOut} !== out_p) upd_cnt++;
    out_p = {AD_Address, AD_BCDOut};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int sat(input int v);
    return (v > 999) ? 999 : v;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_frame(input logic [3:0] ch, input logic [11:0] data);
`ifdef AD_AVG_EN
    if (avg_n == 0 || avg_ch != ch) begin
      avg_sum = int'(data);
      avg_n   = 1;
      avg_ch  = ch;
    end else begin
      avg_sum = avg_sum + int'(data);
      avg_n++;
    end
    if (avg_n == 4) begin
      exp_out = {ch, to_bcd(sat(avg_sum / 16))};
      avg_n   = 0;
    end
`else
    exp_out = {ch, to_bcd(sat(int'(data) / 4))};
`endif
  endtask

  task automatic model_reset();
    exp_out   = '0;
    have_prev = 1'b0;
`ifdef AD_AVG_EN
    avg_n     = 0;
`endif
  endtask

  // Release reset and measure how long CS stays high before the first frame
  task automatic release_and_count(input string tag);
    int n;
    Sys_RST = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (CS === 1'b1 && n < TMO);
    check(tag, 32'(n), 32'(T_QUIET));
  endtask

  task automatic frame_check(input string tag, input logic [3:0] exp_sent, input int mid_sw);
    int n;
    int base;
    logic [15:0] prev_exp;
    base     = upd_cnt;
    prev_exp = exp_out;
    n = 0;
    while (CS !== 1'b0 && n < TMO) begin @(negedge CLK); n++; end
    if (mid_sw >= 0) begin
      repeat (40) @(negedge CLK);
      Switch = 2'(mid_sw);
    end
    while (CS !== 1'b1 && n < TMO) begin @(negedge CLK); n++; end
    repeat (12) @(negedge CLK);
    check({tag, "_done"}, 32'(n < TMO), 32'd1);
    check({tag, "_pulses"}, 32'(rec_pulses), 32'd16);
    check({tag, "_sent_addr"}, 32'(rec_addr), 32'(exp_sent));
    if (have_prev) model_frame(prev_sent, rec_data);
    have_prev = 1'b1;
    prev_sent = exp_sent;
    check({tag, "_out"}, 32'({AD_Address, AD_BCDOut}), 32'(exp_out));
    check({tag, "_updates"}, 32'(upd_cnt - base), (exp_out != prev_exp) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int n;
    logic [1:0] sw;
    for (int c = 0; c < 4; c++) adc_mem[c] = 12'h000;
    adc_mem[2] = 12'h800;

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_cs", 32'(CS), 32'd1);
    check("rst_sclk", 32'(SCLK), 32'd0);
    check("rst_sdo", 32'(SDO), 32'd0);
    check("rst_bcd", 32'(AD_BCDOut), 32'h000);
    check("rst_addr", 32'(AD_Address), 32'h0);
    release_and_count("first_cs_fall");

    // Directed conversions on channel 2
    frame_check("f1", 4'd2, -1);
    frame_check("f2", 4'd2, -1);
`ifndef AD_AVG_EN
    check("f2_bcd_512", 32'(AD_BCDOut), 32'h512);
    check("f2_addr_2", 32'(AD_Address), 32'h2);
`endif
    adc_mem[2] = 12'hFFF;
    frame_check("f3", 4'd2, -1);
`ifndef AD_AVG_EN
    check("f3_bcd_sat", 32'(AD_BCDOut), 32'h999);
`endif
    adc_mem[2] = 12'h07B;
    frame_check("f4", 4'd2, -1);
`ifndef AD_AVG_EN
    check("f4_bcd_030", 32'(AD_BCDOut), 32'h030);
`endif
    adc_mem[2] = 12'h000;
    frame_check("f5", 4'd2, -1);
`ifndef AD_AVG_EN
    check("f5_bcd_000", 32'(AD_BCDOut), 32'h000);
`endif

    // Switch 01 -> 11 in the middle of a frame
    Switch = 2'd1;
    adc_mem[1] = 12'h4D2;
    adc_mem[3] = 12'hA5A;
    frame_check("f6", 4'd1, -1);
    frame_check("f7_toggle", 4'd1, 3);
    frame_check("f8", 4'd3, -1);
`ifndef AD_AVG_EN
    check("f8_addr_still_1", 32'(AD_Address), 32'h1);
`endif
    frame_check("f9", 4'd3, -1);
`ifndef AD_AVG_EN
    check("f9_addr_3", 32'(AD_Address), 32'h3);
`endif

    // Randomized frames, with occasional values around the saturation point
    for (int i = 0; i < 12; i++) begin
      sw = 2'($urandom_range(0, 3));
      Switch = sw;
      for (int c = 0; c < 4; c++) begin
        case (i % 4)
          1:       adc_mem[c] = 12'(16'hF9C + 16'($urandom_range(0, 7)));
          2:       adc_mem[c] = 12'($urandom_range(0, 15));
          default: adc_mem[c] = 12'($urandom);
        endcase
      end
      if (i % 3 == 0) Switch = prev_sent[1:0];
      frame_check("rnd", {2'b00, Switch}, -1);
    end

    // Reset pulsed during bit 8 of a frame
    Switch = 2'd2;
    n = 0;
    while (CS !== 1'b0 && n < TMO) begin @(negedge CLK); n++; end
    @(negedge CLK);
    while (pulses < 8 && n < TMO) begin @(negedge CLK); n++; end
    check("midrst_reached_bit8", 32'(n < TMO), 32'd1);
    Sys_RST = 1'b1;
    @(negedge CLK);
    model_reset();
    check("midrst_cs", 32'(CS), 32'd1);
    check("midrst_sclk", 32'(SCLK), 32'd0);
    check("midrst_sdo", 32'(SDO), 32'd0);
    check("midrst_bcd", 32'(AD_BCDOut), 32'h000);
    check("midrst_addr", 32'(AD_Address), 32'h0);
    release_and_count("midrst_cs_fall");

    // Fresh pipeline after reset; four channel-1 samples 0x400,0x400,0x800,0x800
    Switch = 2'd0;
    frame_check("p0", 4'd2, -1);
    check("p0_no_update", 32'({AD_Address, AD_BCDOut}), 32'h0000);
    Switch = 2'd1;
    frame_check("p1", 4'd1, -1);
    adc_mem[1] = 12'h400;
    frame_check("p2", 4'd1, -1);
    adc_mem[1] = 12'h400;
    frame_check("p3", 4'd1, -1);
    adc_mem[1] = 12'h800;
    frame_check("p4", 4'd1, -1);
    adc_mem[1] = 12'h800;
    frame_check("p5", 4'd1, -1);
`ifdef AD_AVG_EN
    check("avg_bcd_384", 32'(AD_BCDOut), 32'h384);
`else
    check("p5_bcd_512", 32'(AD_BCDOut), 32'h512);
`endif
    check("p5_addr_1", 32'(AD_Address), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
